rht_buffer: RTL and testbench

- Register History Table (RHT): circular buffer holding one rename-history entry per renamed instruction, written in program order.
- Each entry is {architectural dest, new physical dest, previous physical dest}. Each entry's index is issued as that instruction's RHT ticket.
- Sits between rename and the recovery walker:
  - supplies the allocation pointer `rht_id_out` to the walker;
  - serves the walker's per-cycle reads at `walk_point`;
  - accepts its pointer redirect (`rht_set_ptr`/`new_pointer`) when the walk finishes.
- Retires the oldest entry on commit and returns its previous physical register to the free list.

---
 rtl/rht_buffer.sv | 114 +++++++++++
 tb/tb_rht_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rht_buffer.sv
// Register history table: circular rename-history buffer with a walker read port.
// Optional feature: define RHT_CHECKPOINT_GUARD_EN to protect the checkpoint group holding head.
module rht_buffer #(
  parameter int unsigned RHT_ID_WIDTH = 8,
  parameter int unsigned L_ADDR       = 5,
  parameter int unsigned P_ADDR       = 7,
  parameter int unsigned K            = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic [L_ADDR-1:0]       alloc_ldst,
  input  logic [P_ADDR-1:0]       alloc_pdst,
  input  logic [P_ADDR-1:0]       alloc_old_pdst,
  output logic [RHT_ID_WIDTH-1:0] rht_id_out,
  input  logic                    commit_en,
  output logic                    release_valid,
  output logic [P_ADDR-1:0]       release_preg,
  input  logic [RHT_ID_WIDTH-1:0] walk_point,
  input  logic                    rec_state,
  input  logic                    in_reclaim,
  input  logic                    rht_set_ptr,
  input  logic [RHT_ID_WIDTH-1:0] new_pointer,
  output logic                    restore_valid,
  output logic [L_ADDR-1:0]       restore_ldst,
  output logic [P_ADDR-1:0]       restore_pdst,
  output logic                    reclaim_valid,
  output logic [P_ADDR-1:0]       reclaim_preg
);
  localparam int unsigned DEPTH = 2 ** RHT_ID_WIDTH;
  localparam int unsigned CNT_W = RHT_ID_WIDTH + 1;
`ifdef RHT_CHECKPOINT_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [L_ADDR-1:0] ldst;
    logic [P_ADDR-1:0] pdst;
    logic [P_ADDR-1:0] old_pdst;
  } rht_entry_t;

  rht_entry_t mem_q [DEPTH];

  logic [RHT_ID_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    release_valid_q, release_valid_d;
  logic [P_ADDR-1:0]       release_preg_q, release_preg_d;
  logic                    alloc_fire, commit_fire;
  logic [RHT_ID_WIDTH-1:0] head_ofs, live_w;
  logic [CNT_W-1:0]        cap, live;

  // Capacity, handshakes and next-state pointers/count.
  always_comb begin
    head_ofs        = head_q & RHT_ID_WIDTH'(K - 1);
    cap             = GUARD_EN ? (CNT_W'(DEPTH) - CNT_W'(head_ofs)) : CNT_W'(DEPTH);
    alloc_ready     = ~rec_state & (count_q < cap);
    alloc_fire      = alloc_valid & alloc_ready;
    commit_fire     = commit_en & (count_q != '0);
    live_w          = new_pointer - head_q;
    live            = (live_w == '0) ? CNT_W'(DEPTH) : CNT_W'(live_w);
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    release_valid_d = commit_fire;
    release_preg_d  = release_preg_q;
    if (commit_fire) begin
      head_d         = head_q + RHT_ID_WIDTH'(1);
      release_preg_d = mem_q[head_q].old_pdst;
    end
    // A redirect replaces the tail and recomputes occupancy from the pre-commit head.
    if (rht_set_ptr) begin
      tail_d  = new_pointer;
      count_d = live - CNT_W'(commit_fire);
    end else begin
      if (alloc_fire) tail_d = tail_q + RHT_ID_WIDTH'(1);
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      release_valid_q <= 1'b0;
      release_preg_q  <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      release_valid_q <= release_valid_d;
      release_preg_q  <= release_preg_d;
    end
  end

  // Entry storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      mem_q[tail_q] <= '{ldst: alloc_ldst, pdst: alloc_pdst, old_pdst: alloc_old_pdst};
    end
  end

  assign rht_id_out    = tail_q;
  assign release_valid = release_valid_q;
  assign release_preg  = release_preg_q;
  assign restore_valid = rec_state & ~in_reclaim;
  assign restore_ldst  = mem_q[walk_point].ldst;
  assign restore_pdst  = mem_q[walk_point].pdst;
  assign reclaim_valid = in_reclaim;
  assign reclaim_preg  = mem_q[walk_point].pdst;
endmodule

// File: tb/tb_rht_buffer.sv
// Testbench for rht_buffer: directed scenarios plus randomized traffic against a queue-level model.
module tb_rht_buffer;
  localparam int DEPTH = 256;
  localparam int K     = 32;
`ifdef RHT_CHECKPOINT_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       av, ce, rec, recl, sp;
  logic [4:0] a_l;
  logic [6:0] a_p, a_o;
  logic [7:0] wp, np;
  logic       alloc_ready, release_valid, restore_valid, reclaim_valid;
  logic [7:0] rht_id_out;
  logic [6:0] release_preg, restore_pdst, reclaim_preg;
  logic [4:0] restore_ldst;

  rht_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid(av), .alloc_ready(alloc_ready), .alloc_ldst(a_l), .alloc_pdst(a_p),
    .alloc_old_pdst(a_o), .rht_id_out(rht_id_out), .commit_en(ce),
    .release_valid(release_valid), .release_preg(release_preg), .walk_point(wp),
    .rec_state(rec), .in_reclaim(recl), .rht_set_ptr(sp), .new_pointer(np),
    .restore_valid(restore_valid), .restore_ldst(restore_ldst), .restore_pdst(restore_pdst),
    .reclaim_valid(reclaim_valid), .reclaim_preg(reclaim_preg)
  );

  always #5 clk = ~clk;

  // Model: entries by ticket, plus head index and live-entry count.
  int  m_ldst [DEPTH];
  int  m_pdst [DEPTH];
  int  m_old  [DEPTH];
  bit  m_wr   [DEPTH];
  int  mhead, mcount;
  int  errors = 0, checks = 0;

  function automatic int mtail();
    return (mhead + mcount) % DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    av = 0; ce = 0; rec = 0; recl = 0; sp = 0; wp = '0; np = '0;
    a_l = '0; a_p = '0; a_o = '0;
  endtask

  // One clock: check comb outputs, advance model at the edge, check registered outputs.
  task automatic tick();
    int  cap, live, head0, exp_rp;
    bit  exp_ready, afire, cfire;
    #2;
    cap       = DEPTH - (GUARD ? (mhead % K) : 0);
    exp_ready = !rec && (mcount < cap);
    chk("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
    chk("rht_id_out", 32'(rht_id_out), 32'(mtail()));
    chk("restore_valid", 32'(restore_valid), 32'(rec && !recl));
    chk("reclaim_valid", 32'(reclaim_valid), 32'(recl));
    if (rec && m_wr[wp]) begin
      chk("restore_ldst", 32'(restore_ldst), 32'(m_ldst[wp]));
      chk("restore_pdst", 32'(restore_pdst), 32'(m_pdst[wp]));
      chk("reclaim_preg", 32'(reclaim_preg), 32'(m_pdst[wp]));
    end
    afire  = av && exp_ready;
    cfire  = ce && (mcount != 0);
    exp_rp = m_old[mhead];
    @(posedge clk);
    if (afire) begin
      m_ldst[mtail()] = a_l; m_pdst[mtail()] = a_p; m_old[mtail()] = a_o; m_wr[mtail()] = 1;
    end
    head0 = mhead;
    if (cfire) mhead = (mhead + 1) % DEPTH;
    if (sp) begin
      live = (int'(np) - head0 + DEPTH) % DEPTH;
      if (live == 0) live = DEPTH;
      mcount = live - (cfire ? 1 : 0);
      // Re-express the tail as head + count.
      if (mcount == 0 && (int'(np) != mhead)) mcount = (int'(np) - mhead + DEPTH) % DEPTH;
    end else begin
      mcount = mcount + (afire ? 1 : 0) - (cfire ? 1 : 0);
    end
    #1;
    chk("release_valid", 32'(release_valid), 32'(cfire));
    if (cfire) chk("release_preg", 32'(release_preg), 32'(exp_rp));
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(posedge clk); #1;
    mhead = 0; mcount = 0;
    chk("rst_rht_id_out", 32'(rht_id_out), 32'd0);
    chk("rst_release_valid", 32'(release_valid), 32'd0);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    rst = 0;
  endtask

  task automatic alloc_rand(input int n, input bit with_commit);
    for (int i = 0; i < n; i++) begin
      idle();
      av = 1; a_l = 5'($urandom); a_p = 7'($urandom); a_o = 7'($urandom);
      ce = with_commit;
      tick();
    end
    idle();
  endtask

  task automatic commit_n(input int n);
    for (int i = 0; i < n; i++) begin
      idle(); ce = 1; tick();
    end
    idle();
  endtask

  int walk_left;

  initial begin
    rst = 1; idle();
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
    mhead = 0; mcount = 0;
    do_reset();

    // Three allocations: tickets 0,1,2, then walk read of entry 1.
    for (int i = 0; i < 3; i++) begin
      idle(); av = 1; a_l = 5'(i + 1); a_p = 7'(40 + i); a_o = 7'(10 + i);
      #1 chk("ticket", 32'(rht_id_out), 32'(i));
      tick();
    end
    idle(); #1 chk("rht_id_out_3", 32'(rht_id_out), 32'd3);
    rec = 1; wp = 8'd1;
    #1 chk("walk_pdst_41", 32'(restore_pdst), 32'd41);
    tick(); idle();

    // Fill to 256: not ready; one commit frees a slot and releases entry 0.
    do_reset();
    alloc_rand(DEPTH, 0);
    #1 chk("full_not_ready", 32'(alloc_ready), 32'd0);
    commit_n(1);
    #1 chk("ready_after_commit", 32'(alloc_ready), 32'd1);
    tick();

    // 40 allocations, restore walk 32..35, reclaim 36..38, redirect to 36.
    do_reset();
    alloc_rand(40, 0);
    for (int i = 32; i < 39; i++) begin
      idle(); rec = 1; recl = (i >= 36); wp = 8'(i); tick();
    end
    idle(); rec = 1; recl = 1; sp = 1; np = 8'd36; tick();
    idle(); #1 chk("redirect_tail", 32'(rht_id_out), 32'd36);
    commit_n(37);

    // Head 35, count 2: commit together with redirect to 36.
    do_reset();
    alloc_rand(37, 0);
    commit_n(35);
    idle(); rec = 1; sp = 1; np = 8'd36; ce = 1; tick();
    idle(); ce = 1; tick();
    idle();

    // Tail wrap 255 -> 0 and head wrap.
    do_reset();
    alloc_rand(255, 1);
    commit_n(1);
    idle(); #1 chk("tail_255", 32'(rht_id_out), 32'd255);
    alloc_rand(2, 0);
    commit_n(3);

    // Guard capacity: head 5, count 251.
    do_reset();
    alloc_rand(5, 0);
    commit_n(5);
    alloc_rand(251, 0);
    #1 chk("guard_ready", 32'(alloc_ready), GUARD ? 32'd0 : 32'd1);
    tick();

    // Random traffic with occasional walks and resets.
    do_reset();
    walk_left = 0;
    for (int c = 0; c < 4000; c++) begin
      idle();
      if ($urandom_range(0, 599) == 0) begin
        do_reset(); walk_left = 0; continue;
      end
      if (walk_left == 0 && mcount > 0 && $urandom_range(0, 39) == 0)
        walk_left = $urandom_range(2, 10);
      av = ($urandom_range(0, 2) != 0);
      a_l = 5'($urandom); a_p = 7'($urandom); a_o = 7'($urandom);
      ce = ($urandom_range(0, 2) == 0);
      if (walk_left > 0) begin
        rec  = 1;
        recl = (walk_left <= 2);
        if (mcount > 0) wp = 8'((mhead + $urandom_range(0, mcount - 1)) % DEPTH);
        if (walk_left == 1 && mcount > 1) begin
          sp = 1; np = 8'((mhead + $urandom_range(1, mcount)) % DEPTH);
        end
        walk_left--;
      end
      tick();
    end

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
